// File: rtl/dsss_pkg.sv
// Shared DSSS definitions: FSM state encoding, preamble length and default spreading code.
// Used by both the transmitter and the receive side.
package dsss_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPreamble = 2'd1,
        StData     = 2'd2,
        StGap      = 2'd3
    } dsss_state_e;

    localparam int unsigned PreambleSyms = 4;
    localparam int unsigned DataSyms     = 8;
    localparam logic [63:0] DefaultCode  = 64'h0000_0000_9E37_79B9;

endpackage

// File: rtl/chip_timer.sv
// Chip timing for the DSSS transmitter: per-chip strobe, end-of-symbol strobe and
// chip index within the current symbol. Counters are held at zero while disabled.
module chip_timer #(
    parameter int unsigned CHIP_DIV = 16,
    parameter int unsigned CODE_LEN = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    output logic                        chip_stb,
    output logic                        sym_end,
    output logic [$clog2(CODE_LEN)-1:0] chip_idx
);

    localparam int unsigned DivW = $clog2(CHIP_DIV);
    localparam int unsigned IdxW = $clog2(CODE_LEN);

    logic [DivW-1:0] div_q;
    logic [IdxW-1:0] idx_q;

    assign chip_stb = en && (div_q == DivW'(CHIP_DIV - 1));
    assign sym_end  = chip_stb && (idx_q == IdxW'(CODE_LEN - 1));
    assign chip_idx = idx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (!en) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (chip_stb) begin
            div_q <= '0;
            idx_q <= sym_end ? '0 : idx_q + 1'b1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

endmodule

// File: rtl/dsss_tx.sv
// DSSS byte transmitter: spreads each data bit (LSB first) over one code period, then idles
// for a gap. Define DSSS_TX_PREAMBLE_EN to prepend four plain-code preamble symbols.
module dsss_tx
    import dsss_pkg::*;
#(
    parameter int unsigned CHIP_DIV  = 16,
    parameter int unsigned CODE_LEN  = 32,
    parameter logic [63:0] CODE      = DefaultCode,
    parameter int unsigned GAP_CHIPS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx_out,
    output logic       busy
);

    localparam int unsigned IdxW = $clog2(CODE_LEN);
    localparam int unsigned SymW = $clog2(DataSyms);
    localparam int unsigned GapW = $clog2(GAP_CHIPS + 1);

    dsss_state_e     state_q, state_d;
    logic [7:0]      data_q, data_d;
    logic [SymW-1:0] sym_q, sym_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            tx_q, tx_d;
    logic            busy_q;
    logic            chip_stb, sym_end;
    logic [IdxW-1:0] chip_idx;
    logic [CODE_LEN-1:0] code_rev;

    // Reverse the code so chip index k selects CODE[CODE_LEN-1-k] (MSB sent first).
    for (genvar k = 0; k < CODE_LEN; k++) begin : g_code_rev
        assign code_rev[k] = CODE[CODE_LEN-1-k];
    end

    chip_timer #(
        .CHIP_DIV(CHIP_DIV),
        .CODE_LEN(CODE_LEN)
    ) u_chip_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q != StIdle),
        .chip_stb(chip_stb),
        .sym_end (sym_end),
        .chip_idx(chip_idx)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sym_d   = sym_q;
        gap_d   = gap_q;
        tx_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (data_valid) begin
                    data_d = data;
                    sym_d  = '0;
                    gap_d  = '0;
`ifdef DSSS_TX_PREAMBLE_EN
                    state_d = StPreamble;
`else
                    state_d = StData;
`endif
                end
            end
`ifdef DSSS_TX_PREAMBLE_EN
            StPreamble: begin
                tx_d = code_rev[chip_idx];
                if (sym_end) begin
                    if (sym_q == SymW'(PreambleSyms - 1)) begin
                        sym_d   = '0;
                        state_d = StData;
                    end else begin
                        sym_d = sym_q + 1'b1;
                    end
                end
            end
`endif
            StData: begin
                tx_d = code_rev[chip_idx] ^ data_q[sym_q];
                if (sym_end) begin
                    if (sym_q == SymW'(DataSyms - 1)) begin
                        sym_d   = '0;
                        state_d = StGap;
                    end else begin
                        sym_d = sym_q + 1'b1;
                    end
                end
            end
            StGap: begin
                if (chip_stb) begin
                    if (gap_q == GapW'(GAP_CHIPS - 1)) begin
                        gap_d   = '0;
                        state_d = StIdle;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            sym_q   <= '0;
            gap_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sym_q   <= sym_d;
            gap_q   <= gap_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != StIdle);
        end
    end

    assign data_ready = (state_q == StIdle);
    assign tx_out     = tx_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dsss_tx.sv
// Scoreboard bench for dsss_tx with CHIP_DIV=2, CODE_LEN=4, CODE=1010, GAP_CHIPS=1.
// Expected per-cycle outputs are queued at acceptance and checked by a negedge monitor.
module tb_dsss_tx;

    localparam int ChipDiv  = 2;
    localparam int CodeLen  = 4;
    localparam int GapChips = 1;
`ifdef DSSS_TX_PREAMBLE_EN
    localparam int PreSyms = 4;
`else
    localparam int PreSyms = 0;
`endif
    localparam int NSym   = PreSyms + 8;
    localparam int Frame  = (NSym * CodeLen + GapChips) * ChipDiv;
    localparam int Budget = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       tx_out;
    logic       busy;

    dsss_tx #(
        .CHIP_DIV (ChipDiv),
        .CODE_LEN (CodeLen),
        .CODE     (64'hA),
        .GAP_CHIPS(GapChips)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .tx_out    (tx_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic tx;
        logic busy;
        logic ready;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Hand-computed chips for code 1010: plain for bit 0, inverted for bit 1.
    function automatic logic [3:0] sym_chips(input logic b);
        return b ? 4'b0101 : 4'b1010;
    endfunction

    // Expected outputs for cycles j=0..Frame after the acceptance edge.
    task automatic push_frame(input logic [7:0] b);
        logic [47:0] chips;
        int          nchip;
        chips = '0;
        for (int s = 0; s < NSym; s++) begin
            logic sb;
            sb = (s < PreSyms) ? 1'b0 : b[s-PreSyms];
            chips[47-4*s -: 4] = sym_chips(sb);
        end
        nchip = NSym * CodeLen;
        for (int j = 0; j <= Frame; j++) begin
            exp_t e;
            e.busy  = (j < Frame);
            e.ready = !e.busy;
            e.tx    = (j >= 1 && j <= nchip * ChipDiv) ? chips[47-(j-1)/ChipDiv] : 1'b0;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tx_out", int'(tx_out), int'(e.tx));
            check("busy", int'(busy), int'(e.busy));
            check("data_ready", int'(data_ready), int'(e.ready));
        end
    end

    // Present a byte and wait for acceptance; returns just after the acceptance edge.
    task automatic send(input logic [7:0] b, input bit push, input bit drop_valid,
                        output int waited);
        @(negedge clk);
        data       = b;
        data_valid = 1'b1;
        waited     = 0;
        while (!data_ready && waited < Budget) begin
            @(negedge clk);
            waited++;
        end
        if (!data_ready) begin
            check("accept_timeout", waited, -1);
            data_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (push) push_frame(b);
            if (drop_valid) begin
                #1;
                data_valid = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < Budget) begin
            @(negedge clk);
            t++;
        end
        check("drain", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (n < Budget) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w;
        int nb;
        // Reset state
        repeat (2) @(negedge clk);
        check("reset_tx", int'(tx_out), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", int'(data_ready), 1);
        check("idle_tx", int'(tx_out), 0);

        // Single byte 0x01: busy length
        send(8'h01, 1'b1, 1'b1, w);
        count_busy(nb);
        check("busy_cycles_01", nb, Frame);
        drain();

        // All-zero byte (plain code throughout)
        send(8'h00, 1'b1, 1'b1, w);
        count_busy(nb);
        check("busy_cycles_00", nb, Frame);
        drain();

        // Back-to-back with data_valid held high
        send(8'hA5, 1'b1, 1'b0, w);
        send(8'h3C, 1'b1, 1'b1, w);
        check("second_accept_wait", w, Frame);
        drain();

        // data_valid pulse during DATA must be ignored
        send(8'h5A, 1'b1, 1'b1, w);
        repeat (10) @(negedge clk);
        data       = 8'hFF;
        data_valid = 1'b1;
        check("ready_during_data", int'(data_ready), 0);
        @(negedge clk);
        data_valid = 1'b0;
        drain();

        // Asynchronous reset mid-frame (no scoreboard entries for this frame)
        send(8'h00, 1'b0, 1'b1, w);
        @(negedge clk);
        repeat (21) @(negedge clk);
        check("pre_reset_tx", int'(tx_out), 1);
        check("pre_reset_busy", int'(busy), 1);
        #1;
        rst = 1'b0;
        #1;
        check("async_reset_tx", int'(tx_out), 0);
        check("async_reset_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_release", int'(data_ready), 1);
        check("busy_after_release", int'(busy), 0);
        check("tx_after_release", int'(tx_out), 0);

        // Recovery frame
        send(8'h81, 1'b1, 1'b1, w);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
